// File: rtl/bf16_from_int16.sv
// rtl/bf16_from_int16.sv - sequential 16-bit integer to BFloat16 encoder (normalise, then round-to-nearest-even)
// One conversion in flight; valid/ready handshake on both sides.
module bf16_from_int16 #(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_inexact
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [15:0] r_mag;
    logic [8:0]  r_exp;
    logic        r_sign;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [15:0] r_out_data;
    logic        r_out_inexact;

    logic        w_sign;
    logic [15:0] w_mag;
    logic [6:0]  w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [7:0]  w_mant_rnd;
    logic [7:0]  w_exp_rnd;
    logic        w_norm_done;

    assign w_sign = SIGNED_IN & in_data[15];
    // 0x8000 negates to itself, which is the correct 32768 magnitude when read unsigned
    assign w_mag  = w_sign ? (~in_data + 16'd1) : in_data;

    assign w_mant     = r_mag[14:8];
    assign w_guard    = r_mag[7];
    assign w_sticky   = |r_mag[6:0];
    assign w_round_up = w_guard & (w_sticky | r_mag[8]);
    assign w_mant_rnd = {1'b0, w_mant} + {7'd0, w_round_up};
    // A carry out of the mantissa leaves its low bits zero, so only the exponent moves
    assign w_exp_rnd  = r_exp[7:0] + {7'd0, w_mant_rnd[7]};

    assign w_norm_done = r_mag[15] | (r_exp <= 9'd127);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_mag         <= 16'd0;
            r_exp         <= 9'd0;
            r_sign        <= 1'b0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_data    <= 16'h0000;
            r_out_inexact <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign     <= w_sign;
                        r_mag      <= w_mag;
                        r_exp      <= 9'd142;
                        r_in_ready <= 1'b0;
                        if (w_mag == 16'd0) begin
                            r_out_data    <= 16'h0000;
                            r_out_inexact <= 1'b0;
                            r_out_valid   <= 1'b1;
                            r_state       <= S_DONE;
                        end else begin
                            r_state <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    if (w_norm_done) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_mag <= {r_mag[14:0], 1'b0};
                        r_exp <= r_exp - 9'd1;
                    end
                end
                S_ROUND: begin
                    r_out_data    <= {r_sign, w_exp_rnd, w_mant_rnd[6:0]};
                    r_out_inexact <= w_guard | w_sticky;
                    r_out_valid   <= 1'b1;
                    r_state       <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_inexact = r_out_inexact;

endmodule

// File: tb/tb_bf16_from_int16.sv
// tb/tb_bf16_from_int16.sv - randomized and directed bench for bf16_from_int16 against a value-level model
module tb_bf16_from_int16;

    typedef struct {
        logic [15:0] din;
        logic [15:0] data;
        logic        inexact;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid    [2];
    logic        in_ready    [2];
    logic [15:0] in_data     [2];
    logic        out_valid   [2];
    logic        out_ready   [2];
    logic [15:0] out_data    [2];
    logic        out_inexact [2];

    exp_t q [2][$];
    bit   seen [2];
    int   cyc;
    int   n_chk;
    int   n_fail;

    bf16_from_int16 #(.SIGNED_IN(1'b1)) u_dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_inexact(out_inexact[0])
    );

    bf16_from_int16 #(.SIGNED_IN(1'b0)) u_dut_u (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_inexact(out_inexact[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Value-level model: integer magnitude, floor(log2), then RNE on the dropped bits.
    function automatic exp_t model(input logic [15:0] d, input bit signed_in);
        exp_t r;
        int   v, p, e, qv, sh, rem, half, m;
        bit   sg;
        sg = signed_in && d[15];
        v  = sg ? (65536 - int'(d)) : int'(d);
        r.din = d;
        r.acc = 0;
        if (v == 0) begin
            r.data = 16'h0000; r.inexact = 1'b0; r.lat = 1;
            return r;
        end
        p = 0;
        while ((v >> (p + 1)) != 0) p++;
        e = 127 + p;
        r.inexact = 1'b0;
        if (p <= 7) begin
            m = (v << (7 - p)) - 128;
        end else begin
            sh   = p - 7;
            qv   = v >> sh;
            rem  = v - (qv << sh);
            half = 1 << (sh - 1);
            r.inexact = (rem != 0);
            if (rem > half || (rem == half && (qv % 2) == 1)) qv++;
            if (qv == 256) begin qv = 128; e++; end
            m = qv - 128;
        end
        r.data = {sg, 8'(e), 7'(m)};
        r.lat  = (15 - p) + 3;
        return r;
    endfunction

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s ch%0d cyc=%0d actual=0x%0h required=0x%0h", nm, c, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            if (!rst_n) begin
                chk("reset_out_valid", c, 32'(out_valid[c]), 32'd0);
                chk("reset_in_ready", c, 32'(in_ready[c]), 32'd1);
                chk("reset_out_data", c, 32'(out_data[c]), 32'd0);
            end else if (q[c].size() == 0) begin
                chk("idle_in_ready", c, 32'(in_ready[c]), 32'd1);
                chk("idle_out_valid", c, 32'(out_valid[c]), 32'd0);
            end else begin
                e = q[c][0];
                chk("busy_in_ready", c, 32'(in_ready[c]), 32'd0);
                if (out_valid[c]) begin
                    if (!seen[c]) begin
                        chk("latency", c, 32'(cyc - e.acc), 32'(e.lat));
                        seen[c] = 1'b1;
                    end
                    chk("out_data", c, 32'(out_data[c]), 32'(e.data));
                    chk("out_inexact", c, 32'(out_inexact[c]), 32'(e.inexact));
                    if (out_ready[c]) begin
                        void'(q[c].pop_front());
                        seen[c] = 1'b0;
                    end
                end else if (seen[c] || (cyc - e.acc) > 40) begin
                    chk("out_valid_timeout_or_drop", c, 32'(out_valid[c]), 32'd1);
                    void'(q[c].pop_front());
                    seen[c] = 1'b0;
                end
            end
        end
    end

    task automatic send(input int c, input logic [15:0] d);
        exp_t e;
        int   k;
        @(posedge clk); #1;
        in_valid[c] = 1'b1;
        in_data[c]  = d;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready[c]) break;
        end
        if (k == 200) begin
            chk("accept_timeout", c, 32'(in_ready[c]), 32'd1);
            in_valid[c] = 1'b0;
            return;
        end
        e = model(d, c == 0);
        e.acc = cyc;
        @(posedge clk);
        q[c].push_back(e);
        #1 in_valid[c] = 1'b0;
    endtask

    task automatic wait_idle(input int c);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (q[c].size() == 0) break;
        end
        if (k == 300) chk("drain_timeout", c, 32'(q[c].size()), 32'd0);
    endtask

    task automatic pin(input logic [15:0] d, input bit s, input logic [15:0] data, input bit inx, input int lat);
        exp_t e;
        e = model(d, s);
        chk("model_pin_data", int'(!s), 32'(e.data), 32'(data));
        chk("model_pin_inexact", int'(!s), 32'(e.inexact), 32'(inx));
        if (lat >= 0) chk("model_pin_latency", int'(!s), 32'(e.lat), 32'(lat));
    endtask

    initial begin
        logic [15:0] dirs [10];
        logic [15:0] v;
        bit          stop;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid[c] = 1'b0; in_data[c] = 16'h0; out_ready[c] = 1'b1; seen[c] = 1'b0;
        end

        pin(16'd17,   1'b1, 16'h4188, 1'b0, 14);
        pin(16'hFFEF, 1'b1, 16'hC188, 1'b0, 14);
        pin(16'd1520, 1'b1, 16'h44BE, 1'b0, -1);
        pin(16'd0,    1'b1, 16'h0000, 1'b0, 1);
        pin(16'h8000, 1'b1, 16'hC700, 1'b0, 3);
        pin(16'd257,  1'b1, 16'h4380, 1'b1, -1);
        pin(16'd259,  1'b1, 16'h4382, 1'b1, -1);
        pin(16'h7FFF, 1'b1, 16'h4700, 1'b1, -1);
        pin(16'hFFEF, 1'b0, 16'h4780, 1'b1, 3);
        pin(16'h8000, 1'b0, 16'h4700, 1'b0, -1);
        pin(16'd1,    1'b1, 16'h3F80, 1'b0, 18);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        dirs = '{16'd17, 16'hFFEF, 16'd1520, 16'd0, 16'h8000,
                 16'd257, 16'd259, 16'h7FFF, 16'd1, 16'hFFFF};
        foreach (dirs[i]) begin send(0, dirs[i]); wait_idle(0); end
        foreach (dirs[i]) begin send(1, dirs[i]); wait_idle(1); end

        // Backpressure: result held, a waiting input is refused until the transfer completes
        out_ready[0] = 1'b0;
        send(0, 16'd17);
        fork
            send(0, 16'h0005);
            begin repeat (20) @(posedge clk); #1 out_ready[0] = 1'b1; end
        join
        wait_idle(0);

        // Reset during NORM discards the conversion
        send(0, 16'h0001);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        q[0].delete(); q[1].delete(); seen[0] = 1'b0; seen[1] = 1'b0;
        #1 chk("abort_in_ready", 0, 32'(in_ready[0]), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (25) @(posedge clk);
        send(0, 16'h0002);
        wait_idle(0);

        for (int c = 0; c < 2; c++) begin
            stop = 1'b0;
            fork
                begin
                    for (int n = 0; n < 150; n++) begin
                        v = 16'($urandom);
                        v = v >> $urandom_range(0, 15);
                        if ($urandom_range(0, 3) == 0) v = ~v;
                        send(c, v);
                    end
                    wait_idle(c);
                    stop = 1'b1;
                end
                begin
                    while (!stop) begin
                        @(posedge clk); #1;
                        out_ready[c] = ($urandom_range(0, 3) != 0);
                    end
                    out_ready[c] = 1'b1;
                end
            join
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
